// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: computes a - b LSB first through one full-subtractor cell
// built from two half subtractors, sequenced by an IDLE/RUN/DONE controller.

module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic d1, b1, cell_d, b2, cell_b;

  half_subtractor u_hs0 (.x(sh_a[0]), .y(sh_b[0]), .d(d1),     .bo(b1));
  half_subtractor u_hs1 (.x(d1),      .y(brw),     .d(cell_d), .bo(b2));
  assign cell_b = b1 | b2;

  logic [WIDTH-1:0] res_next;
  assign res_next = {cell_d, res[WIDTH-1:1]};

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, exactly like the hardware.
  // NOTE: the operand/result shift registers are reset too; they are small
  // flops, not a RAM, and a clean reset keeps the first operation deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sh_a       <= '0;
      sh_b       <= '0;
      res        <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            res   <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          res  <= res_next;
          brw  <= cell_b;
          cnt  <= cnt + CW'(1);
          // Result outputs move only here, so partial shifts never reach diff.
          if (cnt == CW'(WIDTH - 1)) begin
            diff       <= res_next;
            borrow_out <= cell_b;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
